// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encoding and sizing helpers for the pulse stretcher
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } ps_state_e;

  function automatic int ps_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle requests into HOLD-high / GAP-low bursts
// with a saturating queue of pending requests and a sticky overflow flag.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int DEPTH       = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       pulse_i,
  input  logic                       ovf_clr_i,
  output logic                       level_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o,
  output logic                       overflow_o
);

  localparam int CW = $clog2(ps_max(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int PW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_INIT  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(DEPTH);

  ps_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          level_q, level_d;

  logic gap_end;
  logic take;
  logic inc;
  logic dec;
  logic drop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    gap_end = (state_q == ST_GAP) && (cnt_q == '0);
    dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pulse_i) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_INIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          // A request arriving on the last gap cycle is consumed by the next burst directly.
          if ((pend_q != '0) || pulse_i) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_INIT;
            dec     = (pend_q != '0) && !pulse_i;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    take = pulse_i && (state_q != ST_IDLE) && !gap_end;
    drop = take && (pend_q == PEND_MAX);
    inc  = take && (pend_q != PEND_MAX);

    if (inc) begin
      pend_d = pend_q + PW'(1);
    end else if (dec) begin
      pend_d = pend_q - PW'(1);
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end

    level_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
    end
  end

  assign level_o    = level_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed self-checking bench for pulse_stretcher (4/2/3)
module tb_pulse_stretcher;

  logic       clk_i;
  logic       rst_ni;
  logic       pulse_i;
  logic       ovf_clr_i;
  logic       level_o;
  logic       busy_o;
  logic [1:0] pending_o;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;
  int bursts;
  logic prev_level;

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .DEPTH(3)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .pulse_i    (pulse_i),
    .ovf_clr_i  (ovf_clr_i),
    .level_o    (level_o),
    .busy_o     (busy_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed %0d expected %0d", tag, e, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input logic lv, input logic bz,
                         input logic [1:0] pd, input logic ov);
    chk({tag, ".level"}, e, {31'd0, level_o}, {31'd0, lv});
    chk({tag, ".busy"}, e, {31'd0, busy_o}, {31'd0, bz});
    chk({tag, ".pending"}, e, {30'd0, pending_o}, {30'd0, pd});
    chk({tag, ".overflow"}, e, {31'd0, overflow_o}, {31'd0, ov});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    pulse_i = 1'b0;
    ovf_clr_i = 1'b0;
    while (busy_o && n < 60) begin
      tick();
      n++;
    end
    chk({tag, ".idle_bound"}, n, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    logic       lv, bz, ov;
    logic [1:0] pd;

    rst_ni = 1'b0;
    pulse_i = 1'b0;
    ovf_clr_i = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst_ni = 1'b1;
    tick();
    chk_all("post_reset", 0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Single pulse in cycle 0: high on edges 1-4, gap 5-6, idle at 7.
    for (int e = 0; e < 8; e++) begin
      pulse_i = (e == 0);
      tick();
      lv = (e + 1 <= 4);
      bz = (e + 1 <= 6);
      chk_all("single", e + 1, lv, bz, 2'd0, 1'b0);
    end

    // Pulses in cycles 0 and 2: one queued, second burst on edges 7-10.
    for (int e = 0; e < 13; e++) begin
      int k;
      k = e + 1;
      pulse_i = (e == 0) || (e == 2);
      tick();
      lv = (k <= 4) || (k >= 7 && k <= 10);
      bz = (k <= 12);
      pd = (k >= 3 && k <= 6) ? 2'd1 : 2'd0;
      chk_all("two", k, lv, bz, pd, 1'b0);
    end

    // Five consecutive pulses: queue saturates, overflow from edge 5, four bursts.
    bursts = 0;
    prev_level = 1'b0;
    for (int e = 0; e < 26; e++) begin
      int k;
      k = e + 1;
      pulse_i = (e <= 4);
      tick();
      if (level_o && !prev_level) bursts++;
      prev_level = level_o;
      lv = (k <= 4) || (k >= 7 && k <= 10) || (k >= 13 && k <= 16) || (k >= 19 && k <= 22);
      bz = (k <= 24);
      if (k == 1) pd = 2'd0;
      else if (k == 2) pd = 2'd1;
      else if (k == 3) pd = 2'd2;
      else if (k <= 6) pd = 2'd3;
      else if (k <= 12) pd = 2'd2;
      else if (k <= 18) pd = 2'd1;
      else pd = 2'd0;
      ov = (k >= 5);
      chk_all("burst5", k, lv, bz, pd, ov);
    end
    chk("burst5.count", 26, bursts, 32'd4);
    pulse_i = 1'b0;
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    chk("burst5.ovf_clr", 27, {31'd0, overflow_o}, 32'd0);

    // Asynchronous reset in mid-HOLD, then a clean burst.
    pulse_i = 1'b1;
    tick();
    pulse_i = 1'b1;
    tick();
    pulse_i = 1'b1;
    tick();
    pulse_i = 1'b0;
    chk_all("pre_async", 3, 1'b1, 1'b1, 2'd2, 1'b0);
    #3;
    rst_ni = 1'b0;
    #1;
    chk_all("async_rst", 3, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    rst_ni = 1'b1;
    pulse_i = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      pulse_i = 1'b0;
      chk_all("after_rst", e + 1, (e + 1 <= 4), (e + 1 <= 6), 2'd0, 1'b0);
    end
    wait_idle("after_rst");

    // Pulse on the last gap cycle with pending=1: pending unchanged, no overflow.
    for (int e = 0; e < 19; e++) begin
      int k;
      k = e + 1;
      pulse_i = (e == 0) || (e == 2) || (e == 6);
      tick();
      lv = (k <= 4) || (k >= 7 && k <= 10) || (k >= 13 && k <= 16);
      bz = (k <= 18);
      pd = (k >= 3 && k <= 12) ? 2'd1 : 2'd0;
      chk_all("gap_end", k, lv, bz, pd, 1'b0);
    end

    // Overflow event wins over clear; a lone clear then drops the flag.
    for (int e = 0; e < 4; e++) begin
      pulse_i = 1'b1;
      tick();
    end
    chk("ovf.full", 4, {30'd0, pending_o}, 32'd3);
    pulse_i = 1'b1;
    ovf_clr_i = 1'b1;
    tick();
    chk("ovf.win", 5, {31'd0, overflow_o}, 32'd1);
    pulse_i = 1'b0;
    ovf_clr_i = 1'b1;
    tick();
    chk("ovf.clr", 6, {31'd0, overflow_o}, 32'd0);
    ovf_clr_i = 1'b0;
    tick();
    chk("ovf.stay", 7, {31'd0, overflow_o}, 32'd0);
    wait_idle("ovf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles the level output stays high per accepted pulse; legal range 1 or more.
REQ-002 Parameter GAP_CYCLES, default 2: mandatory low cycles after each high burst; legal range 1 or more.
REQ-003 Parameter DEPTH, default 3: maximum count of queued (pending) pulses; legal range 1 or more.
REQ-004 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 Resetn  input  1  asynchronous, active-low reset.
REQ-006 pulse  input  1  single-cycle request from the input-conditioning stage; each high cycle counts as one request.
REQ-007 ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-008 level  output  1  stretched output that drives an LED, buzzer or lock actuator.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 pending  output  $clog2(DEPTH+1)  number of queued requests.
REQ-011 overflow  output  1  sticky flag: a request was dropped because the queue was full.

Function
REQ-012 The FSM SHALL have three states: IDLE, HOLD and GAP, with one down-counter sized to $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits.
REQ-013 In IDLE, pulse=1 SHALL move the FSM to HOLD on the next edge, with level=1 from that edge (1-cycle latency); pending SHALL NOT change.
REQ-014 In HOLD, level SHALL be 1 for exactly HOLD_CYCLES cycles, after which the FSM SHALL enter GAP.
REQ-015 In GAP, level SHALL be 0 for exactly GAP_CYCLES cycles.
REQ-016 On the last GAP cycle, if pending>0, the FSM SHALL decrement pending and re-enter HOLD; otherwise it SHALL return to IDLE.
REQ-017 In HOLD or GAP, pulse=1 SHALL increment pending, saturating at DEPTH.
REQ-018 When pulse=1 arrives with pending==DEPTH and no decrement in the same cycle, the request SHALL be dropped and overflow SHALL be set.
REQ-019 When pulse=1 coincides with a GAP-end decrement, pending SHALL remain unchanged and no overflow SHALL be raised.
REQ-020 When ovf_clr=1, overflow SHALL clear on the next edge, except that an overflow event in the same cycle wins and keeps it set.
REQ-021 level SHALL be a registered output with no combinational path from pulse.
REQ-022 busy SHALL be 1 in HOLD and GAP, and 0 in IDLE.

Reset
REQ-023 Resetn=0 SHALL immediately force state=IDLE, counter=0, level=0, busy=0, pending=0 and overflow=0, including mid-HOLD or mid-GAP.
REQ-024 After Resetn deasserts, the first pulse SHALL be honoured on the first rising edge where it is sampled high.

Structure
REQ-025 The IDLE/HOLD/GAP state encoding constants SHALL live in the shared combo-lock package so the lock FSM and debug displays can decode busy states.
REQ-026 The block SHALL be a single module; no sub-module is warranted.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2, DEPTH=3)
REQ-027 Single pulse at edge 0 -> level=1 on edges 1-4, 0 on edges 5-6; busy=1 on edges 1-6 and 0 on edge 7; pending stays 0.
REQ-028 Pulse at edge 0 and again at edge 2 -> pending=1 on edges 3-6; second high burst on edges 7-10; pending=0 from edge 7.
REQ-029 Pulses on edges 0-4 (5 consecutive) -> pending saturates at 3; overflow=1 from edge 5; exactly 4 high bursts total; busy drops after the 4th gap.
REQ-030 Resetn pulled low mid-HOLD (edge 2) -> level, busy, pending and overflow go to 0 without waiting for a clock edge; a later pulse starts a clean 4-cycle burst.
REQ-031 Pulse coinciding with the GAP-end decrement while pending=1 -> pending stays 1 and no overflow is raised.
REQ-032 ovf_clr=1 in the same cycle as a new overflow event -> overflow stays 1; ovf_clr=1 alone on a later cycle -> overflow=0 on the next edge.
